// File: rtl/keypad_hex_entry_pkg.sv
// Shared definitions for the 4x4 hex keypad entry block: FSM encoding,
// debounce defaults and the row-priority helper.
package keypad_hex_entry_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  localparam int unsigned DEBOUNCE_TICKS_DEF = 4;
  localparam int unsigned CNT_W              = 4;

  // Lowest-index active-low row wins when several rows are pulled low.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0]) return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchronizer and stable-sample counter; the FSM decides when the
// counter clears or advances.
module keypad_debounce #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       rows_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [3:0]       rows_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [3:0]       meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Rows idle high (pulled up), so the synchronizer resets to all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
      cnt_q  <= '0;
    end else begin
      meta_q <= rows_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign rows_o = sync_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 keypad scanner with press/release debounce, a one-deep key handshake
// and a six-digit hex shift register for the display.
module keypad_hex_entry
  import keypad_hex_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Tick,
  input  logic [3:0]  Rows,
  output logic [3:0]  Cols,
  output logic        KeyValid,
  output logic [3:0]  KeyCode,
  input  logic        KeyReady,
  output logic [23:0] Data,
  output logic        Dropped
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  kp_state_e        state_q, state_d;
  logic [1:0]       col_q, col_d, row_q, row_d;
  logic [3:0]       rows_s;
  logic [CNT_W-1:0] cnt;
  logic             clr, inc, accept, row_hi;
  logic             kv_q, kv_d, drop_q, drop_d;
  logic [3:0]       code_q, code_d;
  logic [23:0]      data_q, data_d;

  keypad_debounce #(.CNT_W(CNT_W)) u_db (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .rows_i (Rows),
    .clr_i  (clr),
    .inc_i  (inc),
    .rows_o (rows_s),
    .cnt_o  (cnt)
  );

  assign row_hi = rows_s[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    clr     = 1'b0;
    inc     = 1'b0;
    accept  = 1'b0;
    if (Tick) begin
      unique case (state_q)
        SCAN: begin
          if (rows_s == 4'hF) col_d = col_q + 2'd1;
          else begin
            row_d   = low_row(rows_s);
            clr     = 1'b1;
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (row_hi) state_d = SCAN;
          else begin
            inc = 1'b1;
            if (cnt == LAST) begin
              state_d = HELD;
              accept  = 1'b1;
            end
          end
        end
        HELD: begin
          if (row_hi) begin
            clr     = 1'b1;
            state_d = RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (!row_hi) state_d = HELD;
          else begin
            inc = 1'b1;
            if (cnt == LAST) begin
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // A new key while the previous one is still unconsumed is discarded.
  always_comb begin
    kv_d   = kv_q;
    code_d = code_q;
    data_d = data_q;
    drop_d = 1'b0;
    if (kv_q && KeyReady) kv_d = 1'b0;
    if (accept) begin
      if (kv_q && !KeyReady) drop_d = 1'b1;
      else begin
        kv_d   = 1'b1;
        code_d = {row_q, col_q};
        data_d = {data_q[19:0], row_q, col_q};
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      kv_q    <= 1'b0;
      code_q  <= 4'h0;
      data_q  <= 24'h000000;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      kv_q    <= kv_d;
      code_q  <= code_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign Cols     = ~(4'b0001 << col_q);
  assign KeyValid = kv_q;
  assign KeyCode  = code_q;
  assign Data     = data_q;
  assign Dropped  = drop_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: behavioural 4x4 keypad, tick divider,
// handshake scoreboard and table-driven key entry.
module tb_keypad_hex_entry;

  localparam int TICK_DIV = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Tick = 1'b0;
  logic        KeyReady = 1'b0;
  logic [3:0]  Rows, Cols, KeyCode;
  logic        KeyValid, Dropped;
  logic [23:0] Data;

  logic [15:0] keys = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          kv_rises = 0;
  int          drops = 0;
  logic        kv_prev = 1'b0;
  logic [23:0] data_model = '0;

  typedef struct packed {logic [3:0] code; logic [23:0] data;} exp_t;
  exp_t exp_q[$];

  typedef struct {int row; int col; logic [3:0] code;} vec_t;
  vec_t seq[7];

  keypad_hex_entry #(.DEBOUNCE_TICKS(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Tick     (Tick),
    .Rows     (Rows),
    .Cols     (Cols),
    .KeyValid (KeyValid),
    .KeyCode  (KeyCode),
    .KeyReady (KeyReady),
    .Data     (Data),
    .Dropped  (Dropped)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    repeat (TICK_DIV - 1) @(posedge Clock);
    #1 Tick = 1'b1;
    @(posedge Clock);
    #1 Tick = 1'b0;
  end

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    Rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !Cols[c]) Rows[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  initial forever begin
    @(negedge Clock);
    if (KeyValid && !kv_prev) kv_rises++;
    if (Dropped) drops++;
    kv_prev = KeyValid;
    if (Reset && KeyValid && KeyReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got key %0h, expected none", KeyCode);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_code", KeyCode, e.code);
        chk("sb_data", Data, e.data);
      end
    end
  end

  task automatic wait_tick();
    do @(posedge Clock); while (!Tick);
    @(negedge Clock);
  endtask

  task automatic ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic wait_key(input string nm, input int n0);
    int t = 0;
    while (kv_rises == n0 && t < 600) begin
      @(negedge Clock);
      t++;
    end
    chk(nm, kv_rises - n0, 1);
  endtask

  task automatic push(input logic [3:0] code);
    exp_t e;
    data_model = {data_model[19:0], code};
    e.code = code;
    e.data = data_model;
    exp_q.push_back(e);
  endtask

  task automatic press(input int r, input int c);
    keys = '0;
    keys[r*4+c] = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    data_model = '0;
    exp_q.delete();
  endtask

  // With no key down, each tick moves the low column one place up.
  task automatic chk_scan(input string nm);
    logic [3:0] prev;
    for (int i = 0; i < 4; i++) begin
      prev = Cols;
      wait_tick();
      chk(nm, Cols, {prev[2:0], prev[3]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int n0, d0;
    seq[0] = '{1, 1, 4'h5};
    seq[1] = '{1, 0, 4'h4};
    seq[2] = '{0, 3, 4'h3};
    seq[3] = '{0, 2, 4'h2};
    seq[4] = '{0, 1, 4'h1};
    seq[5] = '{0, 0, 4'h0};
    seq[6] = '{1, 3, 4'h7};

    repeat (3) @(negedge Clock);
    chk("rst_cols", Cols, 4'hE);
    chk("rst_valid", KeyValid, 0);
    chk("rst_code", KeyCode, 0);
    chk("rst_data", Data, 0);
    chk("rst_drop", Dropped, 0);
    @(posedge Clock);
    #1 Reset = 1'b1;
    chk_scan("t0_scan");

    // single press, consumer initially stalled
    KeyReady = 1'b0;
    n0 = kv_rises;
    press(2, 1);
    push(4'h9);
    wait_key("t1_valid", n0);
    chk("t1_code", KeyCode, 4'h9);
    chk("t1_data", Data, 24'h000009);
    ticks(6);
    chk("t1_hold_valid", KeyValid, 1);
    chk("t1_hold_code", KeyCode, 4'h9);
    @(posedge Clock);
    #1 KeyReady = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    chk("t1_valid_clear", KeyValid, 0);
    keys = '0;
    ticks(8);
    chk("t1_one_key", kv_rises - n0, 1);

    // bounce never accumulates enough stable samples
    n0 = kv_rises;
    keys = '0;
    for (int i = 0; i < 10; i++) begin
      keys[9] = ~keys[9];
      wait_tick();
    end
    keys = '0;
    ticks(8);
    chk("t2_no_key", kv_rises - n0, 0);
    chk_scan("t2_scan");

    // table-driven entry, wrapping past six digits
    for (int i = 0; i < 7; i++) begin
      n0 = kv_rises;
      press(seq[i].row, seq[i].col);
      push(seq[i].code);
      wait_key($sformatf("t3_key%0d", i), n0);
      keys = '0;
      ticks(8);
    end
    chk("t3_data", Data, 24'h432107);
    chk("t3_sb_empty", exp_q.size(), 0);

    // back-pressure: second key is dropped
    do_reset();
    KeyReady = 1'b0;
    d0 = drops;
    n0 = kv_rises;
    press(0, 3);
    push(4'h3);
    wait_key("t4_first", n0);
    keys = '0;
    ticks(8);
    press(2, 2);
    ticks(14);
    keys = '0;
    ticks(8);
    chk("t4_code", KeyCode, 4'h3);
    chk("t4_data", Data, 24'h000003);
    chk("t4_valid", KeyValid, 1);
    chk("t4_drops", drops - d0, 1);
    @(posedge Clock);
    #1 KeyReady = 1'b1;
    repeat (2) @(negedge Clock);
    chk("t4_sb_empty", exp_q.size(), 0);

    // two rows on one column: lower row wins, one key only
    n0 = kv_rises;
    keys = '0;
    keys[4] = 1'b1;
    keys[12] = 1'b1;
    push(4'h4);
    wait_key("t5_key", n0);
    ticks(10);
    chk("t5_held", kv_rises - n0, 1);
    keys = '0;
    ticks(10);
    chk("t5_one_key", kv_rises - n0, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // reset while a key is held and pending
    KeyReady = 1'b0;
    n0 = kv_rises;
    press(2, 1);
    push(4'h9);
    wait_key("t6_key", n0);
    chk("t6_valid", KeyValid, 1);
    @(posedge Clock);
    #1 Reset = 1'b0;
    keys = '0;
    @(negedge Clock);
    chk("t6_cols", Cols, 4'hE);
    chk("t6_valid_rst", KeyValid, 0);
    chk("t6_code", KeyCode, 0);
    chk("t6_data", Data, 0);
    chk("t6_drop", Dropped, 0);
    @(posedge Clock);
    #1 Reset = 1'b1;
    exp_q.delete();
    data_model = '0;
    KeyReady = 1'b1;
    n0 = kv_rises;
    ticks(15);
    chk("t6_no_spurious", kv_rises - n0, 0);
    chk_scan("t6_scan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
